fifo_cascade_seg: RTL and testbench
===================================

# fifo_cascade_seg

Single-clock, parametrised segmented FIFO for ILA sample storage: a logical FIFO of SEGMENTS × SEG_DEPTH words built from SEGMENTS independent RAM banks, with strict first-in-first-out ordering across bank boundaries. It sits between the trigger/sampling logic (push side) and the readout/UART path (pop side). It adds several features over a plain cascaded FIFO:
- an arbitrary segment count
- a fill-level output
- sticky error flags
- synchronous clear
- a ring (overwrite-oldest) mode for pre-trigger capture

## Interface
Parameters:
- WIDTH, 20, data word width
- SEGMENTS, 3, number of RAM banks (≥1)
- SEG_DEPTH, 1024, words per bank; power of two, ≥2
- ALMOST_EMPTY_OFFSET, 15, ALMOST_EMPTY_o asserted while level ≤ this value
- ALMOST_FULL_OFFSET, 1, ALMOST_FULL_o asserted while level ≥ TOTAL − this value
- RING_MODE, 0, 0 = drop on full, 1 = overwrite oldest on full

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous flush
- PUSH_i  in  1  write request
- DI  in  WIDTH  write data
- POP_i  in  1  read request
- DO  out  WIDTH  read data, registered
- DO_VALID_o  out  1  DO carries the word for an accepted pop
- FULL_o, ALMOST_FULL_o, EMPTY_o, ALMOST_EMPTY_o  out  1 each  status flags
- LEVEL_o  out  $clog2(TOTAL+1)  stored word count
- OVERFLOW_o  out  1  sticky, push dropped
- UNDERFLOW_o  out  1  sticky, pop on empty

## Operation
- TOTAL = SEGMENTS × SEG_DEPTH. TOTAL need not be a power of two.
- Write and read pointers are each a {seg, off} pair.
  - off counts 0..SEG_DEPTH−1.
  - On off wrap, seg increments.
  - seg wraps SEGMENTS−1 → 0.
  - No division or modulo.
- Level register: +1 on an accepted push only, −1 on an accepted pop only, unchanged when both are accepted.
- Push accept rules:
  - level < TOTAL: accepted.
  - level == TOTAL, RING_MODE=0: accepted only together with an accepted pop. Otherwise dropped, OVERFLOW_o set.
  - level == TOTAL, RING_MODE=1: always accepted.
    - Without a pop, the read pointer advances (oldest word discarded) and level stays TOTAL.
    - With a pop, the pop returns the oldest word and the read pointer advances once.
    - OVERFLOW_o is never set in this mode.
- Pop accept rules:
  - level > 0: accepted.
  - level == 0: ignored, UNDERFLOW_o set. A simultaneous push is still accepted.
- Writes go only to bank wr.seg at address wr.off. Reads go only to bank rd.seg.
- Flags are decoded from the level register:
  - EMPTY = level==0
  - FULL = level==TOTAL
  - ALMOST_EMPTY = level ≤ ALMOST_EMPTY_OFFSET
  - ALMOST_FULL = level ≥ TOTAL−ALMOST_FULL_OFFSET
- clear_i:
  - Zeroes both pointers, level, OVERFLOW_o and UNDERFLOW_o.
  - Deasserts DO_VALID_o.
  - Overrides push and pop in the same cycle.
  - Bank contents are not cleared.
- Reset values (async, rst low):
  - DO = 0, DO_VALID_o = 0, LEVEL_o = 0
  - EMPTY_o = 1, ALMOST_EMPTY_o = 1
  - FULL_o = 0, ALMOST_FULL_o = 0
  - OVERFLOW_o = 0, UNDERFLOW_o = 0
  - Pointers = 0
- Reset asserted mid-operation behaves identically to a clear, asynchronously. Data in flight is lost.

## Timing
- Push accepted at edge t: the word is readable by a pop at t+1 at the earliest. Flags and LEVEL_o update at t+1.
- Pop accepted at edge t: DO and DO_VALID_o=1 at t+1.
  - DO_VALID_o is high for exactly one cycle per accepted pop.
  - DO holds its value when DO_VALID_o is low.
- Back-to-back pops give one word per cycle, including across a bank boundary and across the SEGMENTS−1 → 0 wrap.
- Read latency is fixed at 1 cycle: synchronous bank read plus a registered output mux. The mux select is the read segment registered at the accepted pop.
- Flags are pure decodes of registered state. No combinational path from PUSH_i or POP_i to any output.

## Structure
- Sub-module fifo_seg_bank:
  - One SEG_DEPTH × WIDTH simple dual-port RAM on clk.
  - Write port: we, waddr, wdata.
  - Read port: re, raddr, registered rdata.
  - Behavioural, so it is inferable as a block RAM.
  - Instantiated SEGMENTS times in a generate loop.
- Top: pointer pairs, level counter, sticky flags, output mux.
- No shared package. TOTAL, OW = $clog2(SEG_DEPTH), SW = $clog2(SEGMENTS) (min 1) and LW are module localparams.

## Test plan
All scenarios use WIDTH=8, SEGMENTS=3, SEG_DEPTH=4 (TOTAL=12), ALMOST_EMPTY_OFFSET=2, ALMOST_FULL_OFFSET=1.
- Cross-bank order: push 0x01..0x0C, then pop 12 times.
  - Before popping: LEVEL_o=12, FULL_o=1.
  - DO = 0x01..0x0C, each one cycle after its pop. EMPTY_o=1 at end.
- Drop on full: RING_MODE=0, fill to 12, push 0xAA.
  - OVERFLOW_o=1, LEVEL_o stays 12, next pop returns 0x01.
  - Push and pop in the same cycle while full: both accepted, LEVEL_o=12.
- Ring overwrite: RING_MODE=1, push 0x01..0x0F.
  - LEVEL_o=12, OVERFLOW_o=0.
  - Pops return 0x04..0x0F.
- Underflow and simultaneous events:
  - Pop on empty: UNDERFLOW_o=1, no DO_VALID_o.
  - Push 0x55 and pop in the same cycle on empty: LEVEL_o=1, the next pop returns 0x55.
- Flags and clear:
  - Level 2 → ALMOST_EMPTY_o=1; level 3 → ALMOST_EMPTY_o=0.
  - Level 11 → ALMOST_FULL_o=1.
  - clear_i together with push: LEVEL_o=0, sticky flags cleared.
  - rst low mid-burst: all outputs at their reset values immediately.

Source files
------------

// File: rtl/fifo_seg_bank.sv
// One segment of the cascaded FIFO: a simple dual-port RAM with a registered
// read port. The write and read sides share clk. When both ports hit the same
// address in one cycle, the read returns the word stored before the write.
module fifo_seg_bank #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage array write port.
  // NOTE: the array has no reset on purpose; a reset on every word would stop
  // it mapping onto block RAM, and stale contents are never exposed.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read port; holds its last value while re_i is low.
  // NOTE: non-blocking assignment here is what gives read-before-write when
  // the read and write addresses collide in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_cascade_seg.sv
// Segmented FIFO for ILA sample storage: SEGMENTS RAM banks of SEG_DEPTH words
// chained into one logical FIFO with strict ordering across bank boundaries.
// Supports drop-on-full or ring (overwrite-oldest) operation, a fill level,
// sticky overflow/underflow flags and a synchronous clear.
module fifo_cascade_seg #(
  parameter int WIDTH               = 20,
  parameter int SEGMENTS            = 3,
  parameter int SEG_DEPTH           = 1024,
  parameter int ALMOST_EMPTY_OFFSET = 15,
  parameter int ALMOST_FULL_OFFSET  = 1,
  parameter bit RING_MODE           = 1'b0,
  localparam int TOTAL = SEGMENTS * SEG_DEPTH,
  localparam int LW    = $clog2(TOTAL + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             PUSH_i,
  input  logic [WIDTH-1:0] DI,
  input  logic             POP_i,
  output logic [WIDTH-1:0] DO,
  output logic             DO_VALID_o,
  output logic             FULL_o,
  output logic             ALMOST_FULL_o,
  output logic             EMPTY_o,
  output logic             ALMOST_EMPTY_o,
  output logic [LW-1:0]    LEVEL_o,
  output logic             OVERFLOW_o,
  output logic             UNDERFLOW_o
);

  localparam int OW = $clog2(SEG_DEPTH);
  localparam int SW = (SEGMENTS > 1) ? $clog2(SEGMENTS) : 1;

  localparam logic [LW-1:0] LEVEL_FULL = LW'(TOTAL);
  localparam logic [LW-1:0] LEVEL_AE   = LW'(ALMOST_EMPTY_OFFSET);
  localparam logic [LW-1:0] LEVEL_AF   = LW'(TOTAL - ALMOST_FULL_OFFSET);
  localparam logic [OW-1:0] OFF_LAST   = OW'(SEG_DEPTH - 1);
  localparam logic [SW-1:0] SEG_LAST   = SW'(SEGMENTS - 1);

  // Offset within a bank, wrapping at the bank size.
  function automatic logic [OW-1:0] off_inc(input logic [OW-1:0] off);
    return (off == OFF_LAST) ? '0 : off + OW'(1);
  endfunction

  // Bank index: steps only when the offset wraps, and wraps after the last bank.
  function automatic logic [SW-1:0] seg_inc(input logic [SW-1:0] seg,
                                            input logic [OW-1:0] off);
    if (off != OFF_LAST) return seg;
    return (seg == SEG_LAST) ? '0 : seg + SW'(1);
  endfunction

  logic [SW-1:0]    wr_seg_q, wr_seg_d, rd_seg_q, rd_seg_d;
  logic [OW-1:0]    wr_off_q, wr_off_d, rd_off_q, rd_off_d;
  logic [LW-1:0]    level_q, level_d;
  logic [SW-1:0]    sel_q;
  logic             valid_q, ovf_q, unf_q;
  logic             is_empty, is_full;
  logic             push_acc, pop_acc, rd_adv;
  logic [WIDTH-1:0] bank_rdata [SEGMENTS];

  // Accept decisions and next pointer/level values.
  // NOTE: every signal gets a default at the top of the block so no path
  // leaves one unassigned and infers a latch.
  always_comb begin
    is_empty = (level_q == '0);
    is_full  = (level_q == LEVEL_FULL);
    pop_acc  = POP_i && !is_empty && !clear_i;
    push_acc = PUSH_i && !clear_i && (!is_full || pop_acc || RING_MODE);
    // A ring-mode push into a full FIFO without a pop discards the oldest word.
    rd_adv   = pop_acc || (push_acc && is_full);

    wr_seg_d = wr_seg_q;
    wr_off_d = wr_off_q;
    rd_seg_d = rd_seg_q;
    rd_off_d = rd_off_q;
    level_d  = level_q;

    if (push_acc) begin
      wr_seg_d = seg_inc(wr_seg_q, wr_off_q);
      wr_off_d = off_inc(wr_off_q);
    end
    if (rd_adv) begin
      rd_seg_d = seg_inc(rd_seg_q, rd_off_q);
      rd_off_d = off_inc(rd_off_q);
    end
    if (push_acc && !pop_acc && !is_full) begin
      level_d = level_q + LW'(1);
    end else if (pop_acc && !push_acc) begin
      level_d = level_q - LW'(1);
    end
  end

  // Pointers, level, sticky flags and the read-side output mux select.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_seg_q <= '0;
      wr_off_q <= '0;
      rd_seg_q <= '0;
      rd_off_q <= '0;
      level_q  <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (clear_i) begin
      wr_seg_q <= '0;
      wr_off_q <= '0;
      rd_seg_q <= '0;
      rd_off_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_seg_q <= wr_seg_d;
      wr_off_q <= wr_off_d;
      rd_seg_q <= rd_seg_d;
      rd_off_q <= rd_off_d;
      level_q  <= level_d;
      valid_q  <= pop_acc;
      if (pop_acc) sel_q <= rd_seg_q;
      if (PUSH_i && !push_acc) ovf_q <= 1'b1;
      if (POP_i && is_empty) unf_q <= 1'b1;
    end
  end

  for (genvar g = 0; g < SEGMENTS; g++) begin : g_bank
    fifo_seg_bank #(
      .WIDTH (WIDTH),
      .DEPTH (SEG_DEPTH)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we_i    (push_acc && (wr_seg_q == SW'(g))),
      .waddr_i (wr_off_q),
      .wdata_i (DI),
      .re_i    (pop_acc && (rd_seg_q == SW'(g))),
      .raddr_i (rd_off_q),
      .rdata_o (bank_rdata[g])
    );
  end

  // Output mux over the registered bank outputs, steered by the registered
  // segment of the last accepted pop, so DO holds between pops.
  always_comb begin
    DO = '0;
    for (int i = 0; i < SEGMENTS; i++) begin
      if (sel_q == SW'(i)) DO = bank_rdata[i];
    end
  end

  assign DO_VALID_o     = valid_q;
  assign LEVEL_o        = level_q;
  assign EMPTY_o        = (level_q == '0);
  assign FULL_o         = (level_q == LEVEL_FULL);
  assign ALMOST_EMPTY_o = (level_q <= LEVEL_AE);
  assign ALMOST_FULL_o  = (level_q >= LEVEL_AF);
  assign OVERFLOW_o     = ovf_q;
  assign UNDERFLOW_o    = unf_q;

endmodule

// File: tb/tb_fifo_cascade_seg.sv
// Bench for fifo_cascade_seg: a drop-on-full and a ring-mode instance share
// one stimulus stream; each is compared every cycle against a queue model.
module tb_fifo_cascade_seg;

  localparam int TOTAL = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear, push, pop;
  logic [7:0] di;

  logic [7:0] dout [2];
  logic [3:0] level [2];
  logic       dvalid [2], full [2], afull [2], empty [2], aempty [2], ovf [2], unf [2];

  always #5 clk = ~clk;

  fifo_cascade_seg #(
    .WIDTH(8), .SEGMENTS(3), .SEG_DEPTH(4),
    .ALMOST_EMPTY_OFFSET(2), .ALMOST_FULL_OFFSET(1), .RING_MODE(1'b0)
  ) u_drop (
    .clk(clk), .rst(rst), .clear_i(clear), .PUSH_i(push), .DI(di), .POP_i(pop),
    .DO(dout[0]), .DO_VALID_o(dvalid[0]), .FULL_o(full[0]), .ALMOST_FULL_o(afull[0]),
    .EMPTY_o(empty[0]), .ALMOST_EMPTY_o(aempty[0]), .LEVEL_o(level[0]),
    .OVERFLOW_o(ovf[0]), .UNDERFLOW_o(unf[0])
  );

  fifo_cascade_seg #(
    .WIDTH(8), .SEGMENTS(3), .SEG_DEPTH(4),
    .ALMOST_EMPTY_OFFSET(2), .ALMOST_FULL_OFFSET(1), .RING_MODE(1'b1)
  ) u_ring (
    .clk(clk), .rst(rst), .clear_i(clear), .PUSH_i(push), .DI(di), .POP_i(pop),
    .DO(dout[1]), .DO_VALID_o(dvalid[1]), .FULL_o(full[1]), .ALMOST_FULL_o(afull[1]),
    .EMPTY_o(empty[1]), .ALMOST_EMPTY_o(aempty[1]), .LEVEL_o(level[1]),
    .OVERFLOW_o(ovf[1]), .UNDERFLOW_o(unf[1])
  );

  // Reference model: index 0 = drop-on-full, index 1 = ring.
  logic [7:0] mq [2][$];
  logic [7:0] m_do [2];
  logic       m_valid [2], m_ovf [2], m_unf [2];

  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "init";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s got=%0h exp=%0h t=%0t", phase, tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 2; r++) begin
      mq[r].delete();
      m_do[r]    = '0;
      m_valid[r] = 1'b0;
      m_ovf[r]   = 1'b0;
      m_unf[r]   = 1'b0;
    end
  endtask

  // One clock edge of the FIFO behaviour, written in terms of a word queue.
  task automatic model_edge(input int r);
    int sz;
    if (clear) begin
      mq[r].delete();
      m_valid[r] = 1'b0;
      m_ovf[r]   = 1'b0;
      m_unf[r]   = 1'b0;
      return;
    end
    sz = mq[r].size();
    m_valid[r] = 1'b0;
    if (pop) begin
      if (sz > 0) begin
        m_do[r]    = mq[r].pop_front();
        m_valid[r] = 1'b1;
      end else begin
        m_unf[r] = 1'b1;
      end
    end
    if (push) begin
      if (mq[r].size() < TOTAL) begin
        mq[r].push_back(di);
      end else if (r == 1) begin
        void'(mq[r].pop_front());
        mq[r].push_back(di);
      end else begin
        m_ovf[r] = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    int sz;
    for (int r = 0; r < 2; r++) begin
      sz = mq[r].size();
      check($sformatf("r%0d_level", r),  32'(level[r]),  32'(sz));
      check($sformatf("r%0d_empty", r),  32'(empty[r]),  32'(sz == 0));
      check($sformatf("r%0d_full", r),   32'(full[r]),   32'(sz == TOTAL));
      check($sformatf("r%0d_aempty", r), 32'(aempty[r]), 32'(sz <= 2));
      check($sformatf("r%0d_afull", r),  32'(afull[r]),  32'(sz >= TOTAL - 1));
      check($sformatf("r%0d_ovf", r),    32'(ovf[r]),    32'(m_ovf[r]));
      check($sformatf("r%0d_unf", r),    32'(unf[r]),    32'(m_unf[r]));
      check($sformatf("r%0d_valid", r),  32'(dvalid[r]), 32'(m_valid[r]));
      check($sformatf("r%0d_do", r),     32'(dout[r]),   32'(m_do[r]));
    end
  endtask

  // Apply the currently driven inputs for one edge, then compare.
  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic c, input logic pu, input logic [7:0] d, input logic po);
    clear = c;
    push  = pu;
    di    = d;
    pop   = po;
    tick();
    clear = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
  endtask

  task automatic do_clear();
    drive(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; di = '0;
    model_reset();
    #12;
    phase = "reset";
    compare_all();
    rst = 1'b1;

    // Ordered traversal of all three banks.
    phase = "xbank";
    for (int i = 1; i <= 12; i++) drive(1'b0, 1'b1, 8'(i), 1'b0);
    check("level12", 32'(level[0]), 32'd12);
    check("full",    32'(full[0]),  32'd1);
    for (int i = 1; i <= 12; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("pop_word", 32'(dout[0]), 32'(i));
    end
    check("empty_end", 32'(empty[0]), 32'd1);

    // Drop on full, then simultaneous push and pop while full.
    phase = "dropfull";
    do_clear();
    for (int i = 1; i <= 12; i++) drive(1'b0, 1'b1, 8'(i), 1'b0);
    drive(1'b0, 1'b1, 8'hAA, 1'b0);
    check("ovf_set",   32'(ovf[0]),   32'd1);
    check("lvl_stays", 32'(level[0]), 32'd12);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    check("oldest", 32'(dout[0]), 32'h01);
    drive(1'b0, 1'b1, 8'h0D, 1'b0);
    drive(1'b0, 1'b1, 8'h0E, 1'b1);
    check("pushpop_full_lvl", 32'(level[0]), 32'd12);
    check("pushpop_full_do",  32'(dout[0]),  32'h02);

    // Ring overwrite of the three oldest words.
    phase = "ring";
    do_clear();
    for (int i = 1; i <= 15; i++) drive(1'b0, 1'b1, 8'(i), 1'b0);
    check("ring_level", 32'(level[1]), 32'd12);
    check("ring_ovf",   32'(ovf[1]),   32'd0);
    for (int i = 4; i <= 15; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("ring_word", 32'(dout[1]), 32'(i));
    end

    // Underflow and simultaneous push/pop on empty.
    phase = "underflow";
    do_clear();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    check("unf_set",  32'(unf[0]),    32'd1);
    check("no_valid", 32'(dvalid[0]), 32'd0);
    drive(1'b0, 1'b1, 8'h55, 1'b1);
    check("lvl1", 32'(level[0]), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    check("word55", 32'(dout[0]), 32'h55);

    // Almost flags, clear with push, async reset mid-burst.
    phase = "flags";
    do_clear();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 1; i <= 2; i++) drive(1'b0, 1'b1, 8'(i), 1'b0);
    check("ae_at2", 32'(aempty[0]), 32'd1);
    drive(1'b0, 1'b1, 8'h03, 1'b0);
    check("ae_at3", 32'(aempty[0]), 32'd0);
    for (int i = 4; i <= 11; i++) drive(1'b0, 1'b1, 8'(i), 1'b0);
    check("af_at11", 32'(afull[0]), 32'd1);
    drive(1'b1, 1'b1, 8'h77, 1'b0);
    check("clr_level", 32'(level[0]), 32'd0);
    check("clr_unf",   32'(unf[0]),   32'd0);
    for (int i = 1; i <= 5; i++) drive(1'b0, 1'b1, 8'(i + 8'h20), i > 2);
    push = 1'b1; di = 8'h99;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    phase = "async_rst";
    compare_all();
    push = 1'b0;
    #1;
    rst = 1'b1;

    // Randomized traffic on both instances.
    phase = "random";
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 55,
            8'($urandom), $urandom_range(0, 99) < 45);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end

endmodule
